// File: rtl/image_scan_pkg.sv
// image_scan_pkg: scan FSM encoding, APB register map and CTRL/STATUS bit positions
// shared by image_scan_ctrl and its APB register block.
package image_scan_pkg;

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, PUSH, FINISH} state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_N      = 2'd2;
    localparam logic [1:0] ADDR_BASE   = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage

// File: rtl/image_scan_ctrl_apb_regs.sv
// apb_regs: APB decode for image_scan_ctrl; holds N, BASE and the sticky status
// flags, and turns CTRL writes into single-cycle START/ABORT pulses.
module apb_regs
    import image_scan_pkg::*;
#(
    parameter int Amba_Addr_Depth = 20,
    parameter int Amba_Word       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Amba_Addr_Depth-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [Amba_Word-1:0]       PWDATA,
    output logic [Amba_Word-1:0]       PRDATA,
    input  logic                       busy_i,
    input  logic                       set_done_i,
    input  logic                       clr_done_i,
    input  logic                       set_err_i,
    input  logic                       clr_err_i,
    output logic                       start_o,
    output logic                       abort_o,
    output logic [Amba_Word-1:0]       n_o,
    output logic [Amba_Word-1:0]       base_o
);

    logic                 wr;
    logic                 rd;
    logic                 sel_ctrl;
    logic                 sel_stat;
    logic                 sel_n;
    logic                 sel_base;
    logic [Amba_Word-1:0] n_q;
    logic [Amba_Word-1:0] n_d;
    logic [Amba_Word-1:0] base_q;
    logic [Amba_Word-1:0] base_d;
    logic                 done_q;
    logic                 done_d;
    logic                 err_q;
    logic                 err_d;
    logic [2:0]           status;

    assign wr       = PSEL & PENABLE & PWRITE;
    assign rd       = PSEL & ~PWRITE;
    assign sel_ctrl = PADDR == Amba_Addr_Depth'(ADDR_CTRL);
    assign sel_stat = PADDR == Amba_Addr_Depth'(ADDR_STATUS);
    assign sel_n    = PADDR == Amba_Addr_Depth'(ADDR_N);
    assign sel_base = PADDR == Amba_Addr_Depth'(ADDR_BASE);

    // ABORT takes precedence over a START carried in the same write
    assign start_o = wr & sel_ctrl & PWDATA[CTRL_START] & ~PWDATA[CTRL_ABORT];
    assign abort_o = wr & sel_ctrl & PWDATA[CTRL_ABORT];
    assign n_o     = n_q;
    assign base_o  = base_q;

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy_i;
        status[STAT_DONE] = done_q;
        status[STAT_ERR]  = err_q;
        n_d    = (wr & sel_n & ~busy_i) ? PWDATA : n_q;
        base_d = (wr & sel_base & ~busy_i) ? PWDATA : base_q;
        done_d = set_done_i | (done_q & ~clr_done_i);
        err_d  = set_err_i | (err_q & ~clr_err_i);
        PRDATA = !rd     ? '0 :
                sel_stat ? Amba_Word'(status) :
                sel_n    ? n_q :
                sel_base ? base_q : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q    <= '0;
            base_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            n_q    <= n_d;
            base_q <= base_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: rtl/image_scan_ctrl.sv
// image_scan_ctrl: streams an N x N image from pixel memory in raster order,
// one pixel every three cycles, with a new_pixel strobe and an end-of-image pulse.
module image_scan_ctrl
    import image_scan_pkg::*;
#(
    parameter int Amba_Addr_Depth = 20,
    parameter int Amba_Word       = 16,
    parameter int Data_Depth      = 8,
    parameter int Max_Dim         = 256,
    parameter int Mem_Addr_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Amba_Addr_Depth-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [Amba_Word-1:0]       PWDATA,
    output logic [Amba_Word-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       mem_rd_en,
    output logic [Mem_Addr_W-1:0]      mem_rd_addr,
    input  logic [Data_Depth-1:0]      mem_rd_data,
    input  logic                       pix_ready,
    output logic [Data_Depth-1:0]      Pixel_Data,
    output logic                       new_pixel,
    output logic                       Image_Done,
    output logic                       busy
);

    localparam int CW = 2 * $clog2(Max_Dim + 1);
    localparam int HW = CW / 2;

    state_e                state_q;
    logic [CW-1:0]         total_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_inc;
    logic [Data_Depth-1:0] pix_buf_q;
    logic [Data_Depth-1:0] pix_q;
    logic [Mem_Addr_W-1:0] addr_q;
    logic [Mem_Addr_W-1:0] next_addr;
    logic                  rd_en_q;
    logic                  new_pix_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  start;
    logic                  abort;
    logic [Amba_Word-1:0]  n;
    logic [Amba_Word-1:0]  base;
    logic [HW-1:0]         n_lo;
    logic                  idle;
    logic                  n_ok;
    logic                  go;
    logic                  bad;
    logic                  set_done;

    apb_regs #(
        .Amba_Addr_Depth(Amba_Addr_Depth),
        .Amba_Word      (Amba_Word)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .busy_i    (busy_q),
        .set_done_i(set_done),
        .clr_done_i(go),
        .set_err_i (bad),
        .clr_err_i (go),
        .start_o   (start),
        .abort_o   (abort),
        .n_o       (n),
        .base_o    (base)
    );

    assign idle      = state_q == IDLE;
    assign n_ok      = (n != '0) && (n <= Amba_Word'(Max_Dim));
    assign go        = start & idle & n_ok;
    assign bad       = start & idle & ~n_ok;
    assign set_done  = (state_q == FINISH) & ~abort;
    assign n_lo      = HW'(n);
    assign count_inc = count_q + CW'(1);
    // Address arithmetic is modulo the memory size; wrapping past the top is intended
    assign next_addr = Mem_Addr_W'(base) + Mem_Addr_W'(count_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            total_q   <= '0;
            count_q   <= '0;
            pix_buf_q <= '0;
            pix_q     <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            new_pix_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rd_en_q   <= 1'b0;
            new_pix_q <= 1'b0;
            done_q    <= 1'b0;
            if (abort && !idle) begin
                state_q <= IDLE;
                count_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (go) begin
                        state_q <= READ;
                        total_q <= CW'(n_lo) * CW'(n_lo);
                        count_q <= '0;
                        addr_q  <= Mem_Addr_W'(base);
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                    READ: state_q <= CAPTURE;
                    CAPTURE: begin
                        pix_buf_q <= mem_rd_data;
                        state_q   <= PUSH;
                    end
                    PUSH: if (pix_ready) begin
                        pix_q     <= pix_buf_q;
                        new_pix_q <= 1'b1;
                        count_q   <= count_inc;
                        if (count_inc == total_q) begin
                            state_q <= FINISH;
                        end else begin
                            state_q <= READ;
                            addr_q  <= next_addr;
                            rd_en_q <= 1'b1;
                        end
                    end
                    FINISH: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign PREADY      = 1'b1;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = addr_q;
    assign Pixel_Data  = pix_q;
    assign new_pixel   = new_pix_q;
    assign Image_Done  = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_image_scan_ctrl.sv
// tb_image_scan_ctrl: directed register vectors plus hand-written scan sequences
// checked against a behavioural pixel memory and hand-computed timings.
module tb_image_scan_ctrl;

    localparam logic [19:0] A_CTRL = 20'd0;
    localparam logic [19:0] A_STAT = 20'd1;
    localparam logic [19:0] A_N    = 20'd2;
    localparam logic [19:0] A_BASE = 20'd3;

    typedef struct {
        bit          wr;
        logic [19:0] addr;
        logic [15:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] PADDR = '0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [15:0] PWDATA = '0;
    logic [15:0] PRDATA;
    logic        PREADY;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [7:0]  mem_rd_data = '0;
    logic        pix_ready = 1'b1;
    logic [7:0]  Pixel_Data;
    logic        new_pixel;
    logic        Image_Done;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic [7:0]  pix_q [$];
    logic [15:0] addr_q [$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_pix_cyc = 0;
    int          consec = 0;
    bit          prev_np = 1'b0;
    bit          busy_seen = 1'b0;
    int          total_n = 0;
    int          bad_n = 0;

    image_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .pix_ready  (pix_ready),
        .Pixel_Data (Pixel_Data),
        .new_pixel  (new_pixel),
        .Image_Done (Image_Done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    always @(negedge clk) begin
        if (new_pixel) begin
            pix_q.push_back(Pixel_Data);
            last_pix_cyc = cyc;
        end
        if (Image_Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_rd_en) addr_q.push_back(mem_rd_addr);
        if (new_pixel && prev_np) consec++;
        if (busy) busy_seen = 1'b1;
        prev_np = new_pixel;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    task automatic apb_write(input logic [19:0] a, input logic [15:0] d);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(negedge clk);
        PENABLE = 1'b1;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] a, output logic [15:0] d);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        @(negedge clk);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(posedge clk);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic clear_mon();
        pix_q.delete();
        addr_q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input string nm, input int limit);
        int w = 0;
        while (done_cnt == 0 && w < limit) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (12) @(negedge clk);
    endtask

    task automatic check_pixels(input string nm, input logic [15:0] b, input int np);
        logic [15:0] a;
        chk({nm, "_strobes"}, 32'(pix_q.size()), 32'(np));
        for (int i = 0; i < np && i < pix_q.size(); i++) begin
            a = b + 16'(i);
            chk($sformatf("%s_pix%0d", nm, i), 32'(pix_q[i]), 32'(mem[a]));
        end
    endtask

    initial begin
        vec_t        vecs [14];
        logic [15:0] d;
        int          start_cyc;
        int          seen;
        int          n_rd;
        for (int a = 0; a < 65536; a++) mem[a] = a[7:0] ^ a[15:8] ^ 8'hA5;
        mem[16'h10] = 8'h11;
        mem[16'h11] = 8'h22;
        mem[16'h12] = 8'h33;
        mem[16'h13] = 8'h44;
        vecs[0]  = '{1'b1, A_N,    16'd5};
        vecs[1]  = '{1'b0, A_N,    16'd5};
        vecs[2]  = '{1'b1, A_BASE, 16'h1234};
        vecs[3]  = '{1'b0, A_BASE, 16'h1234};
        vecs[4]  = '{1'b0, A_CTRL, 16'h0000};
        vecs[5]  = '{1'b1, 20'd7,  16'hBEEF};
        vecs[6]  = '{1'b0, 20'd7,  16'h0000};
        vecs[7]  = '{1'b0, A_STAT, 16'h0000};
        vecs[8]  = '{1'b1, A_N,    16'd0};
        vecs[9]  = '{1'b1, A_CTRL, 16'h0001};
        vecs[10] = '{1'b0, A_STAT, 16'h0004};
        vecs[11] = '{1'b1, A_N,    16'd257};
        vecs[12] = '{1'b1, A_CTRL, 16'h0001};
        vecs[13] = '{1'b0, A_STAT, 16'h0004};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_new_pixel", 32'(new_pixel), 32'd0);
        chk("rst_done", 32'(Image_Done), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        chk("rst_pixel", 32'(Pixel_Data), 32'd0);
        chk("rst_prdata", 32'(PRDATA), 32'd0);
        chk("pready", 32'(PREADY), 32'd1);
        rst = 1'b1;

        clear_mon();
        busy_seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
            else begin
                apb_read(vecs[i].addr, d);
                chk($sformatf("reg_vec%0d", i), 32'(d), 32'(vecs[i].data));
            end
        end
        repeat (4) @(negedge clk);
        chk("cfg_err_no_rd", 32'(addr_q.size()), 32'd0);
        chk("cfg_err_no_busy", 32'(busy_seen), 32'd0);

        // N=2 basic scan with exact latency
        apb_write(A_BASE, 16'h0010);
        apb_write(A_N, 16'd2);
        clear_mon();
        apb_write(A_CTRL, 16'h0001);
        start_cyc = cyc;
        wait_done("n2", 100);
        check_pixels("n2", 16'h0010, 4);
        chk("n2_first_value", 32'(pix_q.size() > 0 ? pix_q[0] : 8'h00), 32'h11);
        chk("n2_done_cnt", 32'(done_cnt), 32'd1);
        chk("n2_done_latency", 32'(done_cyc - start_cyc), 32'd13);
        chk("n2_done_after_last", 32'(done_cyc - last_pix_cyc), 32'd1);
        apb_read(A_STAT, d);
        chk("n2_status", 32'(d), 32'h2);

        // N=3 with downstream stall during the second pixel
        apb_write(A_BASE, 16'h0020);
        apb_write(A_N, 16'd3);
        clear_mon();
        apb_write(A_CTRL, 16'h0001);
        start_cyc = cyc;
        for (int w = 0; w < 50 && !new_pixel; w++) @(negedge clk);
        chk("n3_first_strobe", 32'(new_pixel), 32'd1);
        pix_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("n3_stall_no_strobe", 32'(new_pixel), 32'd0);
            chk("n3_stall_hold", 32'(Pixel_Data), 32'(mem[16'h0020]));
        end
        pix_ready = 1'b1;
        wait_done("n3", 120);
        check_pixels("n3", 16'h0020, 9);
        chk("n3_done_cnt", 32'(done_cnt), 32'd1);
        chk("n3_done_latency", 32'(done_cyc - start_cyc), 32'd31);

        // N=4 aborted after the fifth strobe
        apb_write(A_BASE, 16'h0040);
        apb_write(A_N, 16'd4);
        clear_mon();
        apb_write(A_CTRL, 16'h0001);
        seen = 0;
        for (int w = 0; w < 200 && seen < 5; w++) begin
            @(negedge clk);
            if (new_pixel) seen++;
        end
        chk("abort_pre_strobes", 32'(seen), 32'd5);
        apb_write(A_CTRL, 16'h0002);
        chk("abort_busy_low", 32'(busy), 32'd0);
        n_rd = addr_q.size();
        repeat (20) @(negedge clk);
        chk("abort_no_rd", 32'(addr_q.size()), 32'(n_rd));
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        check_pixels("abort", 16'h0040, 5);
        apb_read(A_STAT, d);
        chk("abort_status", 32'(d), 32'h0);

        // restart; N write during the scan must be ignored
        clear_mon();
        apb_write(A_CTRL, 16'h0001);
        apb_write(A_N, 16'd8);
        apb_read(A_N, d);
        chk("busy_n_locked", 32'(d), 32'd4);
        wait_done("restart", 150);
        check_pixels("restart", 16'h0040, 16);
        chk("restart_done_cnt", 32'(done_cnt), 32'd1);

        // asynchronous reset while stalled in PUSH
        apb_write(A_BASE, 16'h0050);
        apb_write(A_N, 16'd2);
        clear_mon();
        apb_write(A_CTRL, 16'h0001);
        for (int w = 0; w < 50 && !new_pixel; w++) @(negedge clk);
        pix_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pixel", 32'(Pixel_Data), 32'd0);
        chk("arst_rd_addr", 32'(mem_rd_addr), 32'd0);
        chk("arst_new_pixel", 32'(new_pixel), 32'd0);
        chk("arst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("arst_done", 32'(Image_Done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pix_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_no_done", 32'(done_cnt), 32'd0);
        apb_read(A_N, d);
        chk("arst_n_cleared", 32'(d), 32'd0);

        // address wrap at the top of pixel memory
        apb_write(A_BASE, 16'hFFFE);
        apb_write(A_N, 16'd2);
        clear_mon();
        apb_write(A_CTRL, 16'h0001);
        wait_done("wrap", 100);
        chk("wrap_rd_count", 32'(addr_q.size()), 32'd4);
        if (addr_q.size() == 4) begin
            chk("wrap_addr0", 32'(addr_q[0]), 32'hFFFE);
            chk("wrap_addr1", 32'(addr_q[1]), 32'hFFFF);
            chk("wrap_addr2", 32'(addr_q[2]), 32'h0000);
            chk("wrap_addr3", 32'(addr_q[3]), 32'h0001);
        end
        check_pixels("wrap", 16'hFFFE, 4);
        chk("wrap_done_cnt", 32'(done_cnt), 32'd1);

        chk("no_back_to_back_strobe", 32'(consec), 32'd0);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/image_scan_ctrl.md
Name: image_scan_ctrl

Overview:
- APB-configured sequencer that streams one N×N image from the pixel memory into the image-processing datapath.
- On an APB start command it reads N*N pixels in raster order from a programmable base address.
- Each pixel is presented on Pixel_Data with a one-cycle new_pixel strobe, gated by downstream pix_ready.
- Image_Done pulses once after the last pixel. The block owns the new_pixel/Pixel_Data/Image_Done interface consumed by the Checker_Coverager modport.

Parameters:
- Amba_Addr_Depth, 20, APB PADDR width (20/24/32)
- Amba_Word, 16, APB data width (16/24/32)
- Data_Depth, 8, pixel width in bits
- Max_Dim, 256, largest legal N
- Mem_Addr_W, 16, pixel memory address width; must be ≥ 2*clog2(Max_Dim)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- PADDR  in  Amba_Addr_Depth  APB address
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write
- PWDATA  in  Amba_Word  APB write data
- PRDATA  out  Amba_Word  APB read data
- PREADY  out  1  tied 1, zero wait states
- mem_rd_en  out  1  pixel memory read strobe
- mem_rd_addr  out  Mem_Addr_W  pixel memory address
- mem_rd_data  in  Data_Depth  read data, valid the cycle after mem_rd_en
- pix_ready  in  1  downstream can accept a pixel
- Pixel_Data  out  Data_Depth  current pixel
- new_pixel  out  1  one-cycle strobe, Pixel_Data valid
- Image_Done  out  1  one-cycle end-of-image pulse
- busy  out  1  scan in progress

Behaviour:
- Reset (rst=0, async): state IDLE; all registers 0; PRDATA, mem_rd_en, mem_rd_addr, Pixel_Data, new_pixel, Image_Done, busy = 0.
- APB write: commits at the edge where PSEL&PENABLE&PWRITE. Read: PRDATA driven combinationally when PSEL&!PWRITE, else 0. Unmapped addresses read 0; writes to them are ignored.
- Register map:
  - 0 CTRL (WO): bit0 START, bit1 ABORT; both self-clearing, read 0.
  - 1 STATUS (RO): bit0 busy, bit1 done_sticky, bit2 cfg_err.
  - 2 N (RW, reset 0).
  - 3 BASE (RW, reset 0, low Mem_Addr_W bits used).
- Writes to N/BASE while busy are ignored.
- START in IDLE:
  - If 1 ≤ N ≤ Max_Dim: latch total=N*N, clear count and done_sticky, enter READ.
  - Otherwise set cfg_err and stay IDLE.
  - A valid START clears cfg_err. START while busy is ignored.
- Arithmetic: total and count are 2*clog2(Max_Dim+1) bits wide. mem_rd_addr = BASE + count, modulo 2^Mem_Addr_W (wraps silently).
- FSM (busy=1 in every state except IDLE):
  - READ: mem_rd_en=1 for exactly one cycle → CAPTURE.
  - CAPTURE: pix_buf <= mem_rd_data → PUSH.
  - PUSH: wait while pix_ready=0, holding pix_buf. When pix_ready=1: Pixel_Data <= pix_buf, new_pixel=1 the next cycle, count++. Then if count+1==total → FINISH, else → READ.
  - FINISH: Image_Done=1 for one cycle (the cycle immediately after the last new_pixel), set done_sticky → IDLE.
- Throughput: 3 cycles per pixel with pix_ready held high; N*N*3+1 cycles from START commit to Image_Done.
- Pixel_Data holds its last value between strobes. new_pixel is never high on two consecutive cycles.
- ABORT while busy:
  - Next state IDLE; count cleared.
  - No Image_Done; done_sticky unchanged.
  - A new_pixel already registered completes.
  - START and ABORT in the same write: ABORT wins, START ignored.
- Async reset mid-scan: immediate return to reset values. No Image_Done is generated.

Decomposition:
- Package image_scan_pkg:
  - state enum {IDLE, READ, CAPTURE, PUSH, FINISH}
  - register address constants ADDR_CTRL=0, ADDR_STATUS=1, ADDR_N=2, ADDR_BASE=3
  - CTRL/STATUS bit-index constants
- Sub-module apb_regs: APB decode, N/BASE/status storage, START/ABORT pulse generation.
- Scan FSM and counters live in the top module.

Test Plan:
- N=2, BASE=0x10, mem[0x10..0x13]=0x11,0x22,0x33,0x44, pix_ready=1, START → exactly 4 new_pixel strobes carrying 0x11,0x22,0x33,0x44; Image_Done 1 cycle after the 4th strobe, 13 cycles after the START commit; STATUS reads 0x2.
- N=3, pix_ready low for 5 cycles during pixel 2 → pixel 2 value held, no extra strobe, 9 strobes total, single Image_Done.
- N=0 or N=Max_Dim+1, START → no mem_rd_en, busy stays 0, STATUS=0x4; next valid START clears bit2.
- N=4, ABORT after 5th strobe → busy=0 next cycle, no Image_Done, mem_rd_en stays 0; restart yields 16 strobes.
- Write N=8 while busy (N=4 scan) → readback stays 4; scan ends after 16 strobes.
- rst=0 asynchronously mid-PUSH → all outputs 0 without a clock edge; BASE=0xFFFE, N=2 then wraps addresses to 0xFFFE,0xFFFF,0x0000,0x0001.
